// File: rtl/mcu_rx_decoder_if.sv
// Byte stream from the MCU-link UART receiver: a one-cycle rx_dv strobe qualifies rx_byte.
interface mcu_rx_decoder_if;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output rx_dv, output rx_byte);
  modport slave  (input rx_dv, input rx_byte);
endinterface

// File: rtl/mcu_rx_decoder.sv
// MCU-link command decoder: classifies received bytes by high nibble into registered pulses and held data.
// Optional MCU_VERSION_RX_EN adds the multi-byte version frame collector with inactivity timeout.
module mcu_rx_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 256000
) (
  input  logic                  clk,
  input  logic                  rst,
  mcu_rx_decoder_if.slave       rx,
  output logic                  status_valid,
  output logic [1:0]            slot,
  output logic                  power_amplifier,
  output logic                  audio_amplifier,
  output logic                  slot_ready,
  output logic                  poweron_valid,
  output logic                  poweron,
  output logic                  ack_pulse,
  output logic [3:0]            ack_code,
  output logic                  mcu_version_valid,
  output logic [3:0]            mcu_version_type,
  output logic [63:0]           mcu_version,
  output logic                  frame_error,
  output logic [7:0]            error_count
);

  logic       status_valid_q, status_valid_d;
  logic [1:0] slot_q, slot_d;
  logic       pa_q, pa_d, aa_q, aa_d;
  logic       slot_ready_q, slot_ready_d;
  logic       poweron_valid_q, poweron_valid_d;
  logic       poweron_q, poweron_d;
  logic       ack_pulse_q, ack_pulse_d;
  logic [3:0] ack_code_q, ack_code_d;
  logic       frame_error_q, frame_error_d;
  logic [7:0] error_count_q, error_count_d;
  logic       byte_cmd;

`ifdef MCU_VERSION_RX_EN
  typedef enum logic {IDLE, COLLECT} state_e;
  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [2:0]  idx_q, idx_d;
  logic [19:0] timer_q, timer_d;
  logic [3:0]  hdr_q, hdr_d;
  logic [63:0] mcu_version_q, mcu_version_d;
  logic [3:0]  mcu_version_type_q, mcu_version_type_d;
  logic        mcu_version_valid_q, mcu_version_valid_d;
`endif

  always_comb begin
    status_valid_d  = 1'b0;
    poweron_valid_d = 1'b0;
    ack_pulse_d     = 1'b0;
    frame_error_d   = 1'b0;
    slot_d          = slot_q;
    pa_d            = pa_q;
    aa_d            = aa_q;
    slot_ready_d    = slot_ready_q;
    poweron_d       = poweron_q;
    ack_code_d      = ack_code_q;
    byte_cmd        = 1'b0;
`ifdef MCU_VERSION_RX_EN
    state_d             = state_q;
    shadow_d            = shadow_q;
    idx_d               = idx_q;
    timer_d             = timer_q;
    hdr_d               = hdr_q;
    mcu_version_d       = mcu_version_q;
    mcu_version_type_d  = mcu_version_type_q;
    mcu_version_valid_d = 1'b0;
    if (state_q == COLLECT) begin
      // A byte on the expiry cycle takes priority over the timeout.
      if (rx.rx_dv) begin
        shadow_d = {shadow_q[55:0], rx.rx_byte};
        idx_d    = idx_q + 3'd1;
        timer_d  = '0;
        if (idx_q == 3'd7) begin
          mcu_version_d       = {shadow_q[55:0], rx.rx_byte};
          mcu_version_type_d  = hdr_q;
          mcu_version_valid_d = 1'b1;
          state_d             = IDLE;
        end
      end else if (timer_q == TIMER_LAST) begin
        frame_error_d = 1'b1;
        state_d       = IDLE;
      end else begin
        timer_d = timer_q + 20'd1;
      end
    end else begin
      byte_cmd = rx.rx_dv;
    end
`else
    byte_cmd = rx.rx_dv;
`endif

    if (byte_cmd) begin
      case (rx.rx_byte[7:4])
        4'h1: begin
          ack_code_d  = rx.rx_byte[3:0];
          ack_pulse_d = 1'b1;
        end
        4'h5: begin
          slot_d         = rx.rx_byte[3:2];
          pa_d           = rx.rx_byte[1];
          aa_d           = rx.rx_byte[0];
          status_valid_d = 1'b1;
          slot_ready_d   = 1'b1;
        end
        4'h6: begin
          case (rx.rx_byte[1:0])
            2'b01: begin
              poweron_d       = 1'b1;
              poweron_valid_d = 1'b1;
            end
            2'b10: begin
              poweron_d       = 1'b0;
              poweron_valid_d = 1'b1;
            end
            default: frame_error_d = 1'b1;
          endcase
        end
`ifdef MCU_VERSION_RX_EN
        4'h3: begin
          state_d  = COLLECT;
          hdr_d    = rx.rx_byte[3:0];
          idx_d    = '0;
          timer_d  = '0;
          shadow_d = '0;
        end
`endif
        default: frame_error_d = 1'b1;
      endcase
    end

    error_count_d = error_count_q;
    if (frame_error_d && (error_count_q != 8'hFF)) begin
      error_count_d = error_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_valid_q      <= 1'b0;
      slot_q              <= '0;
      pa_q                <= 1'b0;
      aa_q                <= 1'b0;
      slot_ready_q        <= 1'b0;
      poweron_valid_q     <= 1'b0;
      poweron_q           <= 1'b0;
      ack_pulse_q         <= 1'b0;
      ack_code_q          <= '0;
      frame_error_q       <= 1'b0;
      error_count_q       <= '0;
`ifdef MCU_VERSION_RX_EN
      state_q             <= IDLE;
      shadow_q            <= '0;
      idx_q               <= '0;
      timer_q             <= '0;
      hdr_q               <= '0;
      mcu_version_q       <= '0;
      mcu_version_type_q  <= '0;
      mcu_version_valid_q <= 1'b0;
`endif
    end else begin
      status_valid_q      <= status_valid_d;
      slot_q              <= slot_d;
      pa_q                <= pa_d;
      aa_q                <= aa_d;
      slot_ready_q        <= slot_ready_d;
      poweron_valid_q     <= poweron_valid_d;
      poweron_q           <= poweron_d;
      ack_pulse_q         <= ack_pulse_d;
      ack_code_q          <= ack_code_d;
      frame_error_q       <= frame_error_d;
      error_count_q       <= error_count_d;
`ifdef MCU_VERSION_RX_EN
      state_q             <= state_d;
      shadow_q            <= shadow_d;
      idx_q               <= idx_d;
      timer_q             <= timer_d;
      hdr_q               <= hdr_d;
      mcu_version_q       <= mcu_version_d;
      mcu_version_type_q  <= mcu_version_type_d;
      mcu_version_valid_q <= mcu_version_valid_d;
`endif
    end
  end

  assign status_valid    = status_valid_q;
  assign slot            = slot_q;
  assign power_amplifier = pa_q;
  assign audio_amplifier = aa_q;
  assign slot_ready      = slot_ready_q;
  assign poweron_valid   = poweron_valid_q;
  assign poweron         = poweron_q;
  assign ack_pulse       = ack_pulse_q;
  assign ack_code        = ack_code_q;
  assign frame_error     = frame_error_q;
  assign error_count     = error_count_q;
`ifdef MCU_VERSION_RX_EN
  assign mcu_version_valid = mcu_version_valid_q;
  assign mcu_version_type  = mcu_version_type_q;
  assign mcu_version       = mcu_version_q;
`else
  assign mcu_version_valid = 1'b0;
  assign mcu_version_type  = '0;
  assign mcu_version       = '0;
`endif

endmodule

// File: tb/tb_mcu_rx_decoder.sv
// Scoreboard bench for mcu_rx_decoder: a transaction-level model predicts pulses and data per received byte.
module tb_mcu_rx_decoder;

  localparam int unsigned T = 40;

  typedef enum int {EV_ACK, EV_STATUS, EV_PON, EV_VER, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [63:0] d;
    logic [3:0]  t;
    logic [7:0]  ec;
    longint      cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic status_valid, power_amplifier, audio_amplifier, slot_ready;
  logic poweron_valid, poweron, ack_pulse, mcu_version_valid, frame_error;
  logic [1:0]  slot;
  logic [3:0]  ack_code, mcu_version_type;
  logic [63:0] mcu_version;
  logic [7:0]  error_count;

  mcu_rx_decoder_if rx_if ();

  mcu_rx_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx                (rx_if.slave),
    .status_valid      (status_valid),
    .slot              (slot),
    .power_amplifier   (power_amplifier),
    .audio_amplifier   (audio_amplifier),
    .slot_ready        (slot_ready),
    .poweron_valid     (poweron_valid),
    .poweron           (poweron),
    .ack_pulse         (ack_pulse),
    .ack_code          (ack_code),
    .mcu_version_valid (mcu_version_valid),
    .mcu_version_type  (mcu_version_type),
    .mcu_version       (mcu_version),
    .frame_error       (frame_error),
    .error_count       (error_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  ev_t sbq[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state: what the decoder should hold after the bytes seen so far
  bit          m_in_frame;
  int          m_n;
  longint      m_last;
  logic [63:0] m_payload, m_ver;
  logic [3:0]  m_hdr, m_vtype, m_ack;
  logic [3:0]  m_status;
  logic        m_pon, m_ready;
  logic [7:0]  m_ec;

  function automatic void push(ev_kind_e k, logic [63:0] d, logic [3:0] t, longint c);
    ev_t e;
    if (k == EV_ERR) m_ec = (m_ec == 8'd255) ? 8'd255 : m_ec + 8'd1;
    e.kind = k; e.d = d; e.t = t; e.ec = m_ec; e.cyc = c;
    sbq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_in_frame = 0; m_n = 0; m_last = 0; m_payload = '0; m_ver = '0;
    m_hdr = '0; m_vtype = '0; m_ack = '0; m_status = '0; m_pon = 0; m_ready = 0; m_ec = '0;
  endfunction

  // Called for an edge with no byte: a frame open for T edges since its last byte times out.
  function automatic void model_tick();
    if (m_in_frame && (cyc + 1 == m_last + T)) begin
      m_in_frame = 0;
      push(EV_ERR, '0, '0, cyc + 1);
    end
  endfunction

  function automatic void model_byte(logic [7:0] b);
    longint e = cyc + 1;
    if (m_in_frame) begin
      m_payload = {m_payload[55:0], b};
      m_n++;
      m_last = e;
      if (m_n == 8) begin
        m_in_frame = 0;
        m_ver = m_payload;
        m_vtype = m_hdr;
        push(EV_VER, m_ver, m_vtype, e);
      end
      return;
    end
    case (b[7:4])
      4'h1: begin m_ack = b[3:0]; push(EV_ACK, 64'(b[3:0]), '0, e); end
      4'h5: begin m_status = b[3:0]; m_ready = 1; push(EV_STATUS, 64'(b[3:0]), '0, e); end
      4'h6: begin
        if (b[1:0] == 2'b01 || b[1:0] == 2'b10) begin
          m_pon = (b[1:0] == 2'b01);
          push(EV_PON, 64'(m_pon), '0, e);
        end else push(EV_ERR, '0, '0, e);
      end
`ifdef MCU_VERSION_RX_EN
      4'h3: begin m_in_frame = 1; m_n = 0; m_payload = '0; m_hdr = b[3:0]; m_last = e; end
`endif
      default: push(EV_ERR, '0, '0, e);
    endcase
  endfunction

  task automatic idle(int n);
    rx_if.rx_dv = 1'b0;
    repeat (n) begin
      model_tick();
      @(negedge clk);
    end
  endtask

  task automatic send(logic [7:0] b, int gap);
    idle(gap);
    rx_if.rx_dv   = 1'b1;
    rx_if.rx_byte = b;
    model_byte(b);
    @(negedge clk);
    rx_if.rx_dv = 1'b0;
  endtask

  function automatic logic [4:0] kind_bits(ev_kind_e k);
    case (k)
      EV_ACK:    return 5'b10000;
      EV_STATUS: return 5'b01000;
      EV_PON:    return 5'b00100;
      EV_VER:    return 5'b00010;
      default:   return 5'b00001;
    endcase
  endfunction

  logic [4:0] mon_pulses;
  ev_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_pulses = {ack_pulse, status_valid, poweron_valid, mcu_version_valid, frame_error};
      if (mon_pulses != '0) begin
        chk("one_pulse", 64'($countones(mon_pulses)), 64'd1);
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", 64'(mon_pulses), 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("ev_kind", 64'(mon_pulses), 64'(kind_bits(mon_e.kind)));
          chk("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("error_count", 64'(error_count), 64'(mon_e.ec));
          case (mon_e.kind)
            EV_ACK:    chk("ack_code", 64'(ack_code), mon_e.d);
            EV_STATUS: chk("status", 64'({slot, power_amplifier, audio_amplifier, slot_ready}),
                           64'({mon_e.d[3:0], 1'b1}));
            EV_PON:    chk("poweron", 64'(poweron), mon_e.d);
            EV_VER: begin
              chk("mcu_version", mcu_version, mon_e.d);
              chk("mcu_version_type", 64'(mcu_version_type), 64'(mon_e.t));
            end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int g;
    model_reset();
    rx_if.rx_dv   = 1'b0;
    rx_if.rx_byte = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({status_valid, slot, power_amplifier, audio_amplifier, slot_ready,
        poweron_valid, poweron, ack_pulse, ack_code, mcu_version_valid, mcu_version_type,
        frame_error, error_count}), 64'd0);
    chk("reset_version", mcu_version, 64'd0);
    rst = 1'b0;
    idle(2);

    send(8'h5B, 0);
    idle(3);
`ifdef MCU_VERSION_RX_EN
    send(8'h35, 1);
    send(8'h01, 2);
`endif
    chk("queue_drained_before_reset", 64'(sbq.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", 64'({status_valid, slot, power_amplifier, audio_amplifier, slot_ready,
        poweron_valid, poweron, ack_pulse, ack_code, mcu_version_valid, mcu_version_type,
        frame_error, error_count}), 64'd0);
    chk("midrun_reset_version", mcu_version, 64'd0);
    model_reset();
    rst = 1'b0;
    idle(2);

    send(8'h61, 0); send(8'h62, 2); send(8'h63, 1);
    send(8'h14, 3); send(8'h42, 0);

`ifdef MCU_VERSION_RX_EN
    send(8'h31, 2);
    for (int i = 1; i <= 8; i++) send(8'(i), T / 4 - 1);
    send(8'h3A, 2);
    send(8'h5F, 0); send(8'h11, 0); send(8'h3C, 1); send(8'h62, 0);
    send(8'hFF, 4); send(8'h00, 0); send(8'h5F, 2); send(8'hA5, 0);
    send(8'h32, 1); send(8'h10, 1); send(8'h20, 1); send(8'h30, 1);
    idle(T + 5);
    send(8'h50, 0);
    send(8'h33, 2); send(8'hAA, 0); send(8'hBB, 3);
    send(8'hCC, T - 1);
    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i), 1);
    send(8'h34, 2); send(8'h77, 0);
    send(8'h14, T);
`else
    send(8'h30, 2);
    send(8'h3F, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      g = (r < 15) ? (r % 4) : ((r < 17) ? int'(T) - 1 : int'(T) + 1);
      send(8'($urandom), g);
    end
    idle(T + 5);

    for (int i = 0; i < 300; i++) send(8'hFF, 0);
    idle(T + 5);

    chk("final_status", 64'({slot, power_amplifier, audio_amplifier, slot_ready}), 64'({m_status, m_ready}));
    chk("final_poweron", 64'(poweron), 64'(m_pon));
    chk("final_ack_code", 64'(ack_code), 64'(m_ack));
    chk("final_error_count", 64'(error_count), 64'(m_ec));
    chk("final_mcu_version", mcu_version, m_ver);
    chk("final_mcu_version_type", 64'(mcu_version_type), 64'(m_vtype));
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
